// File: rtl/compare_arbiter_pkg.sv
//------------------------------------------------------------------
// compare_arbiter_pkg: shared FSM state type and func3 encodings
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

package compare_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] FUNC3_SLT  = 3'b010;
  localparam logic [2:0] FUNC3_SLTU = 3'b011;

endpackage

`default_nettype wire

// File: rtl/compare_arbiter_slt_compare_core.sv
//------------------------------------------------------------------
// slt_compare_core: combinational signed/unsigned less-than compare
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module slt_compare_core
  import compare_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        func3,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  output logic              lt,
  output logic              err
);

  always_comb begin
    lt  = 1'b0;
    err = 1'b0;
    case (func3)
      FUNC3_SLT:  lt = ($signed(rs1) < $signed(rs2));
      FUNC3_SLTU: lt = (rs1 < rs2);
      default:    err = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/compare_arbiter.sv
//------------------------------------------------------------------
// compare_arbiter: two-requester round-robin front end for a compare core
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module compare_arbiter
  import compare_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][2:0]        req_func3,
  input  logic [1:0][DATA_W-1:0] req_rs1,
  input  logic [1:0][DATA_W-1:0] req_rs2,
  output logic [1:0]             rsp_valid,
  input  logic [1:0]             rsp_ready,
  output logic                   rsp_out,
  output logic                   rsp_err,
  output logic                   busy
);

  state_t            r_state;
  state_t            w_next;
  logic              r_ptr;
  logic              r_owner;
  logic [2:0]        r_func3;
  logic [DATA_W-1:0] r_rs1;
  logic [DATA_W-1:0] r_rs2;
  logic              r_out;
  logic              r_err;

  logic [1:0]        w_grant;
  logic              w_hs;
  logic              w_win;
  logic              w_lt;
  logic              w_err;

  // Pointer only matters when both requesters contend.
  always_comb begin
    w_grant = 2'b00;
    case (req_valid)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_ptr ? 2'b10 : 2'b01;
      default: w_grant = 2'b00;
    endcase
  end

  assign req_ready = (r_state == ST_IDLE) ? w_grant : 2'b00;
  assign w_hs      = |(req_valid & req_ready);
  assign w_win     = req_ready[1];

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_hs) w_next = ST_EXEC;
      ST_EXEC: w_next = ST_RESP;
      ST_RESP: if (rsp_ready[r_owner]) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_func3 <= 3'b000;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_out   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_owner <= w_win;
        r_ptr   <= ~w_win;
        r_func3 <= req_func3[w_win];
        r_rs1   <= req_rs1[w_win];
        r_rs2   <= req_rs2[w_win];
      end
      if (r_state == ST_EXEC) begin
        r_out <= w_lt;
        r_err <= w_err;
      end
    end
  end

  slt_compare_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .func3 (r_func3),
    .rs1   (r_rs1),
    .rs2   (r_rs2),
    .lt    (w_lt),
    .err   (w_err)
  );

  assign rsp_valid = (r_state == ST_RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_out   = r_out;
  assign rsp_err   = r_err;
  assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_compare_arbiter.sv
//------------------------------------------------------------------
// tb_compare_arbiter: scoreboard bench for compare_arbiter
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module tb_compare_arbiter;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][2:0]  req_func3;
  logic [1:0][31:0] req_rs1;
  logic [1:0][31:0] req_rs2;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic             rsp_out;
  logic             rsp_err;
  logic             busy;

  typedef struct packed {
    logic [1:0] mask;
    logic       out;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  compare_arbiter #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_func3 (req_func3),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Monitor: pops one expectation per consumed response.
  always @(negedge clk) begin
    if ((rsp_valid & rsp_ready) != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {30'd0, rsp_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_owner", {30'd0, rsp_valid}, {30'd0, e.mask});
        check("rsp_out",   {31'd0, rsp_out},   {31'd0, e.out});
        check("rsp_err",   {31'd0, rsp_err},   {31'd0, e.err});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_rsp_out",   {31'd0, rsp_out},   32'd0);
    check("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  // Single-requester transaction with latency checks; operands are
  // scrambled right after acceptance to confirm they were captured.
  task automatic issue(input int idx, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic eo, input logic ee);
    logic       hs;
    logic [1:0] m;
    m = (idx == 1) ? 2'b10 : 2'b01;
    req_func3[idx] = f;
    req_rs1[idx]   = a;
    req_rs2[idx]   = b;
    req_valid[idx] = 1'b1;
    hs = 1'b0;
    for (int k = 0; k < 20 && !hs; k++) begin
      @(negedge clk);
      if (req_ready[idx]) begin
        hs = 1'b1;
        exp_q.push_back('{mask: m, out: eo, err: ee});
      end
      tick();
    end
    req_valid[idx] = 1'b0;
    req_func3[idx] = ~f;
    req_rs1[idx]   = ~a;
    req_rs2[idx]   = ~b;
    if (!hs) begin
      check("hs_timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      check("exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      check("exec_busy",      {31'd0, busy},      32'd1);
      tick();
      @(negedge clk);
      check("lat_rsp_valid",  {30'd0, rsp_valid}, {30'd0, m});
      tick();
    end
  endtask

  initial begin
    int grants;
    logic [1:0] want;
    req_valid = 2'b00;
    req_func3 = '0;
    req_rs1   = '0;
    req_rs2   = '0;
    rsp_ready = 2'b11;
    rst_n     = 1'b0;
    tick();
    do_reset();

    // Basic signed/unsigned cases, single requesters
    issue(0, 3'b010, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0);
    issue(0, 3'b011, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    issue(0, 3'b010, 32'h80000000, 32'h80000000, 1'b0, 1'b0);
    issue(0, 3'b011, 32'h80000000, 32'h80000000, 1'b0, 1'b0);
    issue(1, 3'b011, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0);
    issue(1, 3'b010, 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0);
    issue(0, 3'b000, 32'h00000000, 32'h00000005, 1'b0, 1'b1);
    issue(1, 3'b111, 32'h00000003, 32'h00000009, 1'b0, 1'b1);

    // Response stall with non-owner rsp_ready high and requester 1 waiting
    rsp_ready    = 2'b10;
    req_func3[0] = 3'b010; req_rs1[0] = 32'd5; req_rs2[0] = 32'd7;
    req_valid    = 2'b01;
    @(negedge clk);
    check("stall_grant0", {30'd0, req_ready}, 32'd1);
    exp_q.push_back('{mask: 2'b01, out: 1'b1, err: 1'b0});
    tick();
    req_valid    = 2'b10;
    req_func3[1] = 3'b011; req_rs1[1] = 32'd3; req_rs2[1] = 32'd2;
    @(negedge clk);
    check("stall_exec_ready", {30'd0, req_ready}, 32'd0);
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_rsp_valid", {30'd0, rsp_valid}, 32'd1);
      check("stall_rsp_out",   {31'd0, rsp_out},   32'd1);
      check("stall_req_ready", {30'd0, req_ready}, 32'd0);
      tick();
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    check("consume_req_ready", {30'd0, req_ready}, 32'd0);
    tick();
    @(negedge clk);
    check("post_consume_busy", {31'd0, busy},      32'd0);
    check("post_consume_grant",{30'd0, req_ready}, 32'd2);
    exp_q.push_back('{mask: 2'b10, out: 1'b0, err: 1'b0});
    tick();
    req_valid = 2'b00;
    repeat (4) tick();

    // Round-robin with both requesters valid from reset
    do_reset();
    req_func3[0] = 3'b010; req_rs1[0] = 32'hFFFFFFFF; req_rs2[0] = 32'h0;
    req_func3[1] = 3'b011; req_rs1[1] = 32'hFFFFFFFF; req_rs2[1] = 32'h0;
    req_valid = 2'b11;
    grants = 0;
    want   = 2'b01;
    for (int c = 0; c < 20 && grants < 4; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        check("rr_grant", {30'd0, req_ready}, {30'd0, want});
        exp_q.push_back('{mask: want, out: want[0], err: 1'b0});
        want = ~want;
        grants++;
      end
      tick();
    end
    req_valid = 2'b00;
    check("rr_grant_count", grants, 32'd4);
    repeat (4) tick();

    // Reset during EXEC after a grant to 0 (pointer now favours 1)
    req_func3[0] = 3'b010; req_rs1[0] = 32'd1; req_rs2[0] = 32'd2;
    req_valid = 2'b01;
    @(negedge clk);
    check("pre_rst_grant", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_exec_busy",      {31'd0, busy},      32'd0);
    check("rst_exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    tick();
    req_func3[1] = 3'b010; req_rs1[1] = 32'd9; req_rs2[1] = 32'd4;
    req_valid = 2'b11;
    @(negedge clk);
    check("rst_ptr_grant", {30'd0, req_ready}, 32'd1);
    exp_q.push_back('{mask: 2'b01, out: 1'b1, err: 1'b0});
    tick();
    req_valid = 2'b00;
    repeat (5) tick();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
